// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiplier (shift-add) / divider (restoring), one bit per cycle.
// Define MULDIV_SIGNED_EN to add the sgn port and two's-complement operand handling.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        multordiv,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MULDIV_SIGNED_EN
  input  logic        sgn,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opd_q, opd_d;
  logic            mul_q, mul_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic [W:0]      msum;
  logic [2*W-1:0]  mstep, dstep, step, res;
  logic            dge;
  logic [W-1:0]    ddiff;
  logic [W-1:0]    op_a, op_b;

`ifdef MULDIV_SIGNED_EN
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
`endif

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opd_q};
    mstep = acc_q[0] ? {msum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};
    dge   = (acc_q[2*W-1:W-1] >= {1'b0, opd_q});
    ddiff = acc_q[2*W-2:W-1] - opd_q;
    dstep = dge ? {ddiff, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
    step  = mul_q ? mstep : dstep;
  end

  // Operand magnitudes on capture and sign fix-up of the final iteration
  always_comb begin
    res = step;
`ifdef MULDIV_SIGNED_EN
    op_a = mag(a, sgn & a[W-1]);
    op_b = mag(b, sgn & b[W-1]);
    if (mul_q) begin
      res = (neg_a_q ^ neg_b_q) ? -step : step;
    end else begin
      res[W-1:0]   = (opd_q == '0) ? '1 : mag(step[W-1:0], neg_a_q ^ neg_b_q);
      res[2*W-1:W] = mag(step[2*W-1:W], neg_a_q);
    end
`else
    op_a = a;
    op_b = b;
`endif
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    mul_d   = mul_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_SIGNED_EN
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          mul_d   = multordiv;
          opd_d   = multordiv ? op_a : op_b;
          acc_d   = {{W{1'b0}}, (multordiv ? op_b : op_a)};
`ifdef MULDIV_SIGNED_EN
          neg_a_d = sgn & a[W-1];
          neg_b_d = sgn & b[W-1];
`endif
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
          hi_d    = res[2*W-1:W];
          lo_d    = res[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      mul_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      mul_q   <= mul_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; signed cases run when MULDIV_SIGNED_EN is defined.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, multordiv;
  logic [31:0] a, b;
`ifdef MULDIV_SIGNED_EN
  logic        sgn;
`endif
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .multordiv (multordiv),
    .a         (a),
    .b         (b),
`ifdef MULDIV_SIGNED_EN
    .sgn       (sgn),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, disturb inputs while it runs, wait (bounded) for done.
  // cyc counts edges from the start-sampling edge up to the done edge, inclusive.
  task automatic run_op(input logic m, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output int bcnt);
    multordiv = m; a = x; b = y; start = 1'b1;
    bcnt = 0;
    tick;
    start = 1'b0; a = ~x; b = x ^ y; multordiv = ~m;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; multordiv = 1'b1; a = 32'd5; b = 32'd5;
    tick;
    tick;
    start = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", lo); end
  endtask

  task automatic test_mul_max;
    int cyc, bcnt;
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcnt);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mulmax_latency got %0d exp 33", cyc); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL mulmax_busy_cycles got %0d exp 32", bcnt); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulmax_hi got %h exp fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mulmax_lo got %h exp 00000001", lo); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mulmax_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_div;
    int cyc, bcnt;
    run_op(1'b0, 32'd100, 32'd7, cyc, bcnt);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", cyc); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_lo got %0d exp 14", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_hi got %0d exp 2", hi); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_done_pulse got %b exp 0", done); end
    repeat (9) tick;
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_hold_lo got %0d exp 14", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_hold_hi got %0d exp 2", hi); end
  endtask

  task automatic test_div_zero;
    int cyc, bcnt;
    run_op(1'b0, 32'h1234, 32'h0, cyc, bcnt);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div0_latency got %0d exp 33", cyc); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", lo); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL div0_hi got %h exp 00001234", hi); end
  endtask

  task automatic test_start_ignored;
    int cyc;
    multordiv = 1'b1; a = 32'd3; b = 32'd4; start = 1'b1;
    tick;
    start = 1'b0; a = 32'd7; b = 32'd7;
    cyc = 1;
    while (!done && cyc < 100) begin
      start = (cyc == 5 || cyc == 20);
      tick;
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== 33) begin errors++; $display("FAIL ignore_latency got %0d exp 33", cyc); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got %0d exp 0", hi); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL ignore_lo got %0d exp 12", lo); end
    tick;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_after got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bcnt, n;
    multordiv = 1'b1; a = 32'd5; b = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL abort_hilo got %h %h exp 0 0", hi, lo);
    end
    n = 0;
    repeat (40) begin
      tick;
      if (done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", n); end
    run_op(1'b1, 32'd6, 32'd6, cyc, bcnt);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL abort_next_latency got %0d exp 33", cyc); end
    checks++; if (lo !== 32'd36 || hi !== 32'd0) begin
      errors++; $display("FAIL abort_next_result got %h %h exp 0 36", hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    run_op(1'b1, 32'd6, 32'd7, cyc, bcnt);
    checks++; if (done !== 1'b1 || lo !== 32'd42 || hi !== 32'd0) begin
      errors++; $display("FAIL b2b_first got done=%b hi=%0d lo=%0d exp 1 0 42", done, hi, lo);
    end
    multordiv = 1'b0; a = 32'd9; b = 32'd2; start = 1'b1;
    tick;
    start = 1'b0; a = 32'd0; b = 32'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
    cyc = 1;
    while (!done && cyc < 100) begin
      tick;
      cyc++;
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", cyc); end
    checks++; if (lo !== 32'd4) begin errors++; $display("FAIL b2b_lo got %0d exp 4", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %0d exp 1", hi); end
    tick;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    int cyc, bcnt;
    sgn = 1'b1;
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, cyc, bcnt);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL sdiv got %h %h exp ffffffff fffffffd", hi, lo);
    end
    run_op(1'b1, 32'hFFFFFFFD, 32'd5, cyc, bcnt);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL smul got %h %h exp ffffffff fffffff1", hi, lo);
    end
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, cyc, bcnt);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL sdiv_ovf got %h %h exp 00000000 80000000", hi, lo);
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL s_latency got %0d exp 33", cyc); end
    run_op(1'b0, 32'hFFFFFFF9, 32'd0, cyc, bcnt);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
      errors++; $display("FAIL sdiv0 got %h %h exp fffffff9 ffffffff", hi, lo);
    end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; multordiv = 1'b0; a = '0; b = '0;
`ifdef MULDIV_SIGNED_EN
    sgn = 1'b0;
`endif
    test_reset;
    test_mul_max;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
`ifdef MULDIV_SIGNED_EN
    test_signed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
